// File: rtl/i2c_init_mon_pkg.sv
// Shared CSR word offsets, the default required-register mask
// and the per-channel state type for the I2C init monitor.
package i2c_init_mon_pkg;

  localparam int TFR_CMD    = 0;
  localparam int RX_DATA    = 1;
  localparam int CTRL       = 2;
  localparam int ISER       = 3;
  localparam int ISR        = 4;
  localparam int STATUS     = 5;
  localparam int TFR_LVL    = 6;
  localparam int RX_LVL     = 7;
  localparam int SCL_LOW    = 8;
  localparam int SCL_HIGH   = 9;
  localparam int SDA_HOLD   = 10;

  localparam logic [15:0] DEFAULT_REQ_MASK = 16'h0704;

  typedef enum logic [1:0] {
    IDLE,
    CONFIG,
    DONE,
    TIMEOUT
  } mon_state_e;

  // True for the bus-timing registers a zero value would break.
  function automatic logic is_timing_reg(input logic [3:0] a);
    return (a == 4'(SCL_LOW)) ||
           (a == 4'(SCL_HIGH)) ||
           (a == 4'(SDA_HOLD));
  endfunction

endpackage

// File: rtl/i2c_init_monitor_if.sv
// Snooped CSR write bus plus monitor status for NUM_CH channels.
// Addresses and data are packed per channel, channel 0 lowest.
interface i2c_init_monitor_if #(
  parameter int NUM_CH     = 2,
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
);
  logic [NUM_CH*ADDR_WIDTH-1:0] csr_address;
  logic [NUM_CH-1:0]            csr_write;
  logic [NUM_CH*DATA_WIDTH-1:0] csr_writedata;
  logic [NUM_CH-1:0]            rearm;
  logic [NUM_CH-1:0]            init_done;
  logic                         init_all_done;
  logic [NUM_CH-1:0]            timeout_err;

  modport master (
    output csr_address, csr_write, csr_writedata, rearm,
    input  init_done, init_all_done, timeout_err
  );

  modport slave (
    input  csr_address, csr_write, csr_writedata, rearm,
    output init_done, init_all_done, timeout_err
  );
endinterface

// File: rtl/i2c_init_mon_ch.sv
// One channel: seen mask, enable shadow, stall counter and FSM.
// Option I2C_INIT_MON_ZERO_CHECK_EN: zero timing writes un-see.
module i2c_init_mon_ch
  import i2c_init_mon_pkg::*;
#(
  parameter int          ADDR_WIDTH     = 4,
  parameter int          DATA_WIDTH     = 32,
  parameter logic [15:0] REQ_MASK       = DEFAULT_REQ_MASK,
  parameter int          CTRL_EN_BIT    = 0,
  parameter int          TIMEOUT_CYCLES = 1048576
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_write,
  input  logic [ADDR_WIDTH-1:0] i_address,
  input  logic [DATA_WIDTH-1:0] i_writedata,
  input  logic                  i_rearm,
  output logic                  o_init_done,
  output logic                  o_timeout_err
);

  localparam int CW = (TIMEOUT_CYCLES == 0) ? 1
                    : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

  mon_state_e    r_state, w_state_d;
  logic [15:0]   r_seen, w_seen_d, w_seen_nx;
  logic          r_en, w_en_d, w_en_nx;
  logic [CW-1:0] r_cnt, w_cnt_d, w_cnt_inc;
  logic          r_err, w_err_d;

  logic       w_hit, w_ctrl, w_zero, w_cond;
  logic [3:0] w_idx;

  assign w_idx  = i_address[3:0];
  assign w_hit  = i_write &&
                  ((i_address >> 4) == '0);
  assign w_ctrl = w_hit && (w_idx == 4'(CTRL));

`ifdef I2C_INIT_MON_ZERO_CHECK_EN
  assign w_zero = w_hit && is_timing_reg(w_idx) &&
                  (i_writedata == '0);
`else
  assign w_zero = 1'b0;
`endif

  // Register contents as they would be after this cycle's write.
  always_comb begin
    w_seen_nx = r_seen;
    if (w_hit) w_seen_nx[w_idx] = !w_zero;
    w_en_nx = w_ctrl ? i_writedata[CTRL_EN_BIT] : r_en;
    w_cond  = ((w_seen_nx & REQ_MASK) == REQ_MASK) &&
              w_en_nx;
    w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;
  end

  // Next state, seen mask, enable, counter and sticky error.
  always_comb begin
    w_state_d = r_state;
    w_seen_d  = w_seen_nx;
    w_en_d    = w_en_nx;
    w_cnt_d   = r_cnt;
    w_err_d   = r_err;
    unique case (r_state)
      IDLE: begin
        if (w_hit) begin
          w_cnt_d   = CW'(1);
          w_state_d = w_cond ? DONE : CONFIG;
        end
      end
      CONFIG: begin
        w_cnt_d = w_cnt_inc;
        if (w_cond) begin
          w_state_d = DONE;
        end else if (LIMIT != '0 && r_cnt == LIMIT) begin
          w_state_d = TIMEOUT;
          w_err_d   = 1'b1;
        end
      end
      DONE: begin
        if ((w_ctrl && !w_en_nx) || w_zero) begin
          w_state_d = CONFIG;
          w_cnt_d   = CW'(1);
          if (w_ctrl) w_seen_d[CTRL] = 1'b0;
        end
      end
      TIMEOUT: begin
        if (w_cond) w_state_d = DONE;
      end
      default: w_state_d = IDLE;
    endcase
    if (i_rearm) begin
      w_state_d = IDLE;
      w_seen_d  = '0;
      w_en_d    = 1'b0;
      w_cnt_d   = '0;
      w_err_d   = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_seen  <= '0;
      r_en    <= 1'b0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_seen  <= w_seen_d;
      r_en    <= w_en_d;
      r_cnt   <= w_cnt_d;
      r_err   <= w_err_d;
    end
  end

  assign o_init_done   = (r_state == DONE);
  assign o_timeout_err = r_err;

endmodule

// File: rtl/i2c_init_monitor.sv
// Top: slices the snooped buses into per-channel monitors and
// registers the all-done aggregate. Option: I2C_INIT_MON_ZERO_CHECK_EN.
module i2c_init_monitor
  import i2c_init_mon_pkg::*;
#(
  parameter int          NUM_CH         = 2,
  parameter int          ADDR_WIDTH     = 4,
  parameter int          DATA_WIDTH     = 32,
  parameter logic [15:0] REQ_MASK       = DEFAULT_REQ_MASK,
  parameter int          CTRL_EN_BIT    = 0,
  parameter int          TIMEOUT_CYCLES = 1048576
) (
  input logic             clk,
  input logic             reset,
  i2c_init_monitor_if.slave mon
);

  logic [NUM_CH-1:0] w_done;
  logic [NUM_CH-1:0] w_err;
  logic              r_all_done;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    i2c_init_mon_ch #(
      .ADDR_WIDTH     (ADDR_WIDTH),
      .DATA_WIDTH     (DATA_WIDTH),
      .REQ_MASK       (REQ_MASK),
      .CTRL_EN_BIT    (CTRL_EN_BIT),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_ch (
      .clk           (clk),
      .reset         (reset),
      .i_write       (mon.csr_write[g]),
      .i_address     (mon.csr_address[g*ADDR_WIDTH +: ADDR_WIDTH]),
      .i_writedata   (mon.csr_writedata[g*DATA_WIDTH +: DATA_WIDTH]),
      .i_rearm       (mon.rearm[g]),
      .o_init_done   (w_done[g]),
      .o_timeout_err (w_err[g])
    );
  end

  // Aggregate done, one cycle behind the channel flags.
  always_ff @(posedge clk) begin
    if (reset) r_all_done <= 1'b0;
    else       r_all_done <= &w_done;
  end

  assign mon.init_done     = w_done;
  assign mon.init_all_done = r_all_done;
  assign mon.timeout_err   = w_err;

endmodule

// File: tb/tb_i2c_init_monitor.sv
// Directed bench for i2c_init_monitor: 2 channels, 5-bit addresses,
// 50-cycle timeout. Inputs change and outputs are sampled on negedge.
module tb_i2c_init_monitor;

  localparam int NCH = 2;
  localparam int AW  = 5;
  localparam int DW  = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  i2c_init_monitor_if #(
    .NUM_CH(NCH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)
  ) bus ();

  i2c_init_monitor #(
    .NUM_CH         (NCH),
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .REQ_MASK       (16'h0704),
    .CTRL_EN_BIT    (0),
    .TIMEOUT_CYCLES (50)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .mon   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Caller is at a negedge; returns at the next negedge.
  task automatic wr(input int ch,
                    input logic [AW-1:0] a,
                    input logic [DW-1:0] d);
    bus.csr_write = '0;
    bus.csr_write[ch] = 1'b1;
    bus.csr_address[ch*AW +: AW] = a;
    bus.csr_writedata[ch*DW +: DW] = d;
    @(negedge clk);
    bus.csr_write = '0;
  endtask

  task automatic rearm(input logic [NCH-1:0] m);
    bus.rearm = m;
    @(negedge clk);
    bus.rearm = '0;
  endtask

  task automatic full_seq(input int ch);
    wr(ch, 5'd2, 32'h1);
    wr(ch, 5'd8, 32'h64);
    wr(ch, 5'd9, 32'h64);
    wr(ch, 5'd10, 32'h1E);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.csr_write     = '0;
    bus.csr_address   = '0;
    bus.csr_writedata = '0;
    bus.rearm         = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_done", 32'(bus.init_done), 32'h0);
    check("rst_all",  32'(bus.init_all_done), 32'h0);
    check("rst_err",  32'(bus.timeout_err), 32'h0);

    // Channel 0 configures; done only after the last register.
    wr(0, 5'd2, 32'h1);
    wr(0, 5'd8, 32'h64);
    wr(0, 5'd9, 32'h64);
    check("ch0_partial", 32'(bus.init_done), 32'h0);
    wr(0, 5'd10, 32'h1E);
    check("ch0_done", 32'(bus.init_done), 32'h1);
    check("ch0_all0", 32'(bus.init_all_done), 32'h0);

    // Channel 1 completes; aggregate lags one cycle.
    full_seq(1);
    check("ch1_done", 32'(bus.init_done), 32'h3);
    check("all_lag",  32'(bus.init_all_done), 32'h0);
    @(negedge clk);
    check("all_done", 32'(bus.init_all_done), 32'h1);

    // Disable and re-enable through CTRL.
    wr(0, 5'd2, 32'h0);
    check("dis_done", 32'(bus.init_done), 32'h2);
    check("dis_all_lag", 32'(bus.init_all_done), 32'h1);
    @(negedge clk);
    check("dis_all", 32'(bus.init_all_done), 32'h0);
    wr(0, 5'd2, 32'h1);
    check("reen_done", 32'(bus.init_done), 32'h3);
    wr(0, 5'd5, 32'h0);
    check("other_wr", 32'(bus.init_done), 32'h3);

    rearm(2'b11);
    check("rearm_done", 32'(bus.init_done), 32'h0);

    // Stall on channel 1: error exactly 50 cycles after first count.
    wr(1, 5'd2, 32'h1);
    repeat (49) @(negedge clk);
    check("to_before", 32'(bus.timeout_err), 32'h0);
    @(negedge clk);
    check("to_hit", 32'(bus.timeout_err), 32'h2);
    wr(1, 5'd8, 32'h64);
    wr(1, 5'd9, 32'h64);
    check("to_partial", 32'(bus.init_done), 32'h0);
    wr(1, 5'd10, 32'h1E);
    check("to_late_done", 32'(bus.init_done), 32'h2);
    check("to_sticky", 32'(bus.timeout_err), 32'h2);

    // Rearm beats a same-cycle completing write.
    wr(0, 5'd2, 32'h1);
    wr(0, 5'd8, 32'h64);
    wr(0, 5'd9, 32'h64);
    bus.csr_write[0] = 1'b1;
    bus.csr_address[0 +: AW] = 5'd10;
    bus.csr_writedata[0 +: DW] = 32'h1E;
    bus.rearm = 2'b01;
    @(negedge clk);
    bus.csr_write = '0;
    bus.rearm = '0;
    check("rearm_win", 32'(bus.init_done), 32'h2);
    wr(0, 5'd10, 32'h1E);
    check("rearm_en_clr", 32'(bus.init_done), 32'h2);
    wr(0, 5'd2, 32'h1);
    check("rearm_seen_clr", 32'(bus.init_done), 32'h2);
    wr(0, 5'd8, 32'h64);
    wr(0, 5'd9, 32'h64);
    check("rearm_redo", 32'(bus.init_done), 32'h3);
    rearm(2'b10);
    check("rearm_err_clr", 32'(bus.timeout_err), 32'h0);
    check("rearm1_done", 32'(bus.init_done), 32'h1);

    // Addresses >= 16 are ignored (0x12 must not act as CTRL).
    wr(1, 5'h12, 32'h1);
    wr(1, 5'd8, 32'h64);
    wr(1, 5'd9, 32'h64);
    wr(1, 5'd10, 32'h1E);
    check("hi_addr_ign", 32'(bus.init_done), 32'h1);
    wr(1, 5'd2, 32'h1);
    check("hi_addr_done", 32'(bus.init_done), 32'h3);

    // Completion on the same cycle the counter hits its limit.
    rearm(2'b01);
    wr(0, 5'd2, 32'h1);
    wr(0, 5'd8, 32'h64);
    wr(0, 5'd9, 32'h64);
    repeat (47) @(negedge clk);
    wr(0, 5'd10, 32'h1E);
    check("lim_done", 32'(bus.init_done), 32'h3);
    check("lim_no_err", 32'(bus.timeout_err), 32'h0);
    @(negedge clk);
    check("lim_no_err2", 32'(bus.timeout_err), 32'h0);

    // Zero-valued timing register writes.
    rearm(2'b01);
    wr(0, 5'd2, 32'h1);
    wr(0, 5'd8, 32'h64);
    wr(0, 5'd10, 32'h1E);
    wr(0, 5'd9, 32'h0);
`ifdef I2C_INIT_MON_ZERO_CHECK_EN
    check("zero_blocks", 32'(bus.init_done), 32'h2);
    wr(0, 5'd9, 32'h64);
    check("zero_fixed", 32'(bus.init_done), 32'h3);
    wr(0, 5'd8, 32'h0);
    check("zero_in_done", 32'(bus.init_done), 32'h2);
    wr(0, 5'd8, 32'h64);
    check("zero_refix", 32'(bus.init_done), 32'h3);
`else
    check("zero_counts", 32'(bus.init_done), 32'h3);
`endif
    @(negedge clk);
    check("final_all", 32'(bus.init_all_done), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/i2c_init_monitor.md
Name: i2c_init_monitor

Overview:
- Multi-channel, passive snooper of the write side of the I2C master CSR bus. One channel per I2C master instance (SFP cages).
- Per channel, tracks which required registers have been written and whether the core was enabled via CTRL. Raises init_done for that channel, an aggregate all-done flag, and a timeout error if configuration stalls.
- Sits beside the I2C masters in the SFP controller. Outputs feed the common CSR status bits.

Parameters:
- NUM_CH, 2, number of snooped I2C CSR channels (1..8).
- ADDR_WIDTH, 4, CSR word-address width per channel (>=4).
- DATA_WIDTH, 32, CSR write-data width per channel.
- REQ_MASK, 16'h0704, bit i set = word address i must be written before done (default: CTRL, SCL_LOW, SCL_HIGH, SDA_HOLD).
- CTRL_EN_BIT, 0, bit of CTRL write data that is the core-enable bit.
- TIMEOUT_CYCLES, 1048576, clk cycles allowed from first write to done; 0 disables the timeout.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- csr_address  in  NUM_CH*ADDR_WIDTH  snooped address, channel c at bits [c*ADDR_WIDTH +: ADDR_WIDTH].
- csr_write  in  NUM_CH  snooped write strobe per channel.
- csr_writedata  in  NUM_CH*DATA_WIDTH  snooped write data, packed the same way as csr_address.
- rearm  in  NUM_CH  single-cycle per-channel return to IDLE (software re-init).
- init_done  out  NUM_CH  channel configured and enabled.
- init_all_done  out  1  AND of init_done across all channels (registered).
- timeout_err  out  NUM_CH  sticky: configuration did not complete within TIMEOUT_CYCLES.

Behaviour:
- Reset value of all outputs, state, seen masks and counters is 0 / IDLE.
- Per-channel seen[15:0]:
  - A write to address a<16 sets seen[a] on the next clk.
  - Writes to a>=16 are ignored.
  - Non-required addresses still set seen but do not gate done.
- Per-channel en_q: updated on every CTRL (addr 2) write to writedata[CTRL_EN_BIT].
- Per-channel FSM:
  - IDLE:
    - Any write -> CONFIG; timeout counter loads 1.
    - If that write alone completes the condition (REQ_MASK has a single bit) -> DONE directly.
  - CONFIG:
    - Counter increments each cycle.
    - When (seen_next & REQ_MASK)==REQ_MASK and en_next==1 -> DONE.
    - Else if TIMEOUT_CYCLES!=0 and counter==TIMEOUT_CYCLES -> TIMEOUT.
  - DONE:
    - CTRL write with enable bit 0 -> CONFIG; clears seen[2] and en_q; counter restarts at 1.
    - Other writes are ignored for state purposes.
  - TIMEOUT:
    - timeout_err=1 (sticky).
    - A later completing write still -> DONE; timeout_err stays 1.
- Latency:
  - init_done = (state==DONE), registered. It rises on the clk after the completing write (1 cycle) and falls 1 cycle after a disabling CTRL write.
  - init_all_done lags init_done by 1 cycle.
- Simultaneous events:
  - rearm wins over a same-cycle write: write dropped, state IDLE, seen/en/counter/timeout_err cleared.
  - Counter reaching limit in the same cycle as the completing write -> DONE, no error.
- Counter width = $clog2(TIMEOUT_CYCLES+1). The counter saturates (no wrap) in TIMEOUT/DONE.
- Channels are fully independent; no cross-channel arbitration.

Optional Feature:
- Macro I2C_INIT_MON_ZERO_CHECK_EN.
- Defined: writes of value 0 to SCL_LOW (8), SCL_HIGH (9) or SDA_HOLD (10) do not set the seen bit and do clear it if it was set. In DONE, such a write -> CONFIG.
- Undefined: any write sets the seen bit regardless of data.

Decomposition:
- Package i2c_init_mon_pkg holds:
  - localparam word offsets TFR_CMD..SDA_HOLD (0..10);
  - DEFAULT_REQ_MASK;
  - state enum mon_state_e {IDLE, CONFIG, DONE, TIMEOUT}.
- Sub-module i2c_init_mon_ch: one channel's FSM, seen mask and counter, generated NUM_CH times. The top slices the buses and ANDs done.

Test Plan:
- Ch0 writes CTRL=0x1, SCL_LOW=0x64, SCL_HIGH=0x64 at cycles 10/11/12, then SDA_HOLD=0x1E at cycle 13 -> init_done[0]=1 at cycle 14, init_done[1]=0, init_all_done=0.
- Both channels complete (ch1 last write at cycle 20) -> init_all_done=1 at cycle 22.
- Ch0 DONE, then CTRL=0x0 write -> init_done[0]=0 next cycle. Re-write CTRL=0x1 -> init_done[0]=1 again next cycle.
- TIMEOUT_CYCLES=50: single CTRL write on ch1 at cycle 5 with no further writes -> timeout_err[1]=1 at cycle 56. Later completion -> init_done[1]=1 with timeout_err[1] still 1.
- rearm[0] in the same cycle as the last SDA_HOLD write -> state IDLE, init_done[0]=0, seen cleared. A repeat full sequence then completes normally.
- With I2C_INIT_MON_ZERO_CHECK_EN: SCL_HIGH=0 as the final write -> init_done stays 0. Then SCL_HIGH=0x64 -> init_done=1 next cycle.
